// File: rtl/axi_dma_job_sequencer.sv
// AXI4-Lite master that programs an AXI DMA (simple mode) for one MM2S/S2MM job and polls both channels to idle.
// Optional poll-phase timeout is built in when AXI_DMA_SEQ_TIMEOUT_EN is defined.
module axi_dma_job_sequencer #(
  parameter logic [31:0] DMA_BASE       = 32'h4040_0000,
  parameter int          POLL_INTERVAL  = 5,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] tx_addr,
  input  logic [31:0] rx_addr,
  input  logic [23:0] len_words,
  output logic        busy,
  output logic        done,
  output logic [2:0]  status,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  // state       | meaning
  // S_IDLE      | waiting for start
  // S_WR_REQ    | AW/W of register write idx_q outstanding
  // S_WR_RESP   | waiting for B of register write idx_q
  // S_RD_REQ    | AR of status register for channel ch_q
  // S_RD_RESP   | waiting for R of status read
  // S_POLL_WAIT | idle gap before the next status read
  // S_FINISH    | done pulse, status valid
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WR_REQ    = 3'd1;
  localparam logic [2:0] S_WR_RESP   = 3'd2;
  localparam logic [2:0] S_RD_REQ    = 3'd3;
  localparam logic [2:0] S_RD_RESP   = 3'd4;
  localparam logic [2:0] S_POLL_WAIT = 3'd5;
  localparam logic [2:0] S_FINISH    = 3'd6;

  localparam logic [2:0] ST_OK      = 3'd0;
  localparam logic [2:0] ST_BUSERR  = 3'd1;
  localparam logic [2:0] ST_DMAERR  = 3'd2;
  localparam logic [2:0] ST_TIMEOUT = 3'd3;
  localparam logic [2:0] ST_BADLEN  = 3'd4;

  localparam logic [15:0] POLL_LOAD = 16'(POLL_INTERVAL - 1);

  logic [2:0]  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        ch_q, ch_d;
  logic        aw_pend_q, aw_pend_d;
  logic        w_pend_q, w_pend_d;
  logic        busy_q, busy_d;
  logic [2:0]  status_q, status_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [23:0] len_q, len_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic        tmo_hit;

  logic [31:0] byte_cnt;
  logic [31:0] wr_off;
  logic [31:0] wr_val;
  logic        rdata_unused;

  assign byte_cnt     = {6'd0, len_q, 2'b00};
  assign rdata_unused = ^{m_axi_rdata[31:7], m_axi_rdata[3:2], m_axi_rdata[0]};

  // Order matters: destination first, then source, then run bits, lengths last (length write starts each channel).
  always_comb begin
    wr_off = 32'h0;
    wr_val = 32'h0;
    case (idx_q)
      3'd0: begin wr_off = 32'h48; wr_val = rx_q;     end
      3'd1: begin wr_off = 32'h18; wr_val = tx_q;     end
      3'd2: begin wr_off = 32'h00; wr_val = 32'h1;    end
      3'd3: begin wr_off = 32'h30; wr_val = 32'h1;    end
      3'd4: begin wr_off = 32'h58; wr_val = byte_cnt; end
      3'd5: begin wr_off = 32'h28; wr_val = byte_cnt; end
      default: ;
    endcase
  end

`ifdef AXI_DMA_SEQ_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        in_poll;

  assign in_poll = (state_q == S_RD_REQ) || (state_q == S_RD_RESP) || (state_q == S_POLL_WAIT);
  assign tmo_hit = in_poll && (tmo_cnt_q == 32'd0);

  // Reloaded throughout the write phase so the budget starts with the first poll read.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == S_WR_RESP)
      tmo_cnt_d = 32'(TIMEOUT_CYCLES);
    else if (in_poll && (tmo_cnt_q != 32'd0))
      tmo_cnt_d = tmo_cnt_q - 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tmo_cnt_q <= 32'd0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic [31:0] tmo_unused;
  assign tmo_unused = 32'(TIMEOUT_CYCLES);
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ch_d       = ch_q;
    aw_pend_d  = aw_pend_q;
    w_pend_d   = w_pend_q;
    busy_d     = busy_q;
    status_d   = status_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    len_d      = len_q;
    poll_cnt_d = poll_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          tx_d     = tx_addr;
          rx_d     = rx_addr;
          len_d    = len_words;
          status_d = ST_OK;
          if (len_words == 24'd0) begin
            status_d = ST_BADLEN;
            state_d  = S_FINISH;
          end else begin
            busy_d    = 1'b1;
            idx_d     = 3'd0;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = S_WR_REQ;
          end
        end
      end
      S_WR_REQ: begin
        if (m_axi_awready) aw_pend_d = 1'b0;
        if (m_axi_wready)  w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) begin
            status_d = ST_BUSERR;
            state_d  = S_FINISH;
          end else if (idx_q != 3'd5) begin
            idx_d     = idx_q + 3'd1;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = S_WR_REQ;
          end else begin
            ch_d    = 1'b0;
            state_d = S_RD_REQ;
          end
        end
      end
      S_RD_REQ: begin
        if (m_axi_arready) state_d = S_RD_RESP;
      end
      S_RD_RESP: begin
        if (m_axi_rvalid) begin
          if (m_axi_rresp != 2'b00) begin
            status_d = ST_BUSERR;
            state_d  = S_FINISH;
          end else if (m_axi_rdata[6:4] != 3'b000) begin
            status_d = ST_DMAERR;
            state_d  = S_FINISH;
          end else if (m_axi_rdata[1] && ch_q) begin
            status_d = ST_OK;
            state_d  = S_FINISH;
          end else if (tmo_hit) begin
            status_d = ST_TIMEOUT;
            state_d  = S_FINISH;
          end else if (m_axi_rdata[1]) begin
            ch_d    = 1'b1;
            state_d = S_RD_REQ;
          end else begin
            poll_cnt_d = POLL_LOAD;
            state_d    = S_POLL_WAIT;
          end
        end
      end
      S_POLL_WAIT: begin
        if (tmo_hit) begin
          status_d = ST_TIMEOUT;
          state_d  = S_FINISH;
        end else if (poll_cnt_q == 16'd0) begin
          state_d = S_RD_REQ;
        end else begin
          poll_cnt_d = poll_cnt_q - 16'd1;
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      ch_q       <= 1'b0;
      aw_pend_q  <= 1'b0;
      w_pend_q   <= 1'b0;
      busy_q     <= 1'b0;
      status_q   <= ST_OK;
      tx_q       <= 32'd0;
      rx_q       <= 32'd0;
      len_q      <= 24'd0;
      poll_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ch_q       <= ch_d;
      aw_pend_q  <= aw_pend_d;
      w_pend_q   <= w_pend_d;
      busy_q     <= busy_d;
      status_q   <= status_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      len_q      <= len_d;
      poll_cnt_q <= poll_cnt_d;
    end
  end

  assign busy          = busy_q;
  assign done          = (state_q == S_FINISH);
  assign status        = status_q;
  assign m_axi_awvalid = aw_pend_q;
  assign m_axi_awaddr  = aw_pend_q ? (DMA_BASE + wr_off) : 32'd0;
  assign m_axi_wvalid  = w_pend_q;
  assign m_axi_wdata   = w_pend_q ? wr_val : 32'd0;
  assign m_axi_wstrb   = w_pend_q ? 4'hF : 4'h0;
  assign m_axi_bready  = (state_q == S_WR_RESP);
  assign m_axi_arvalid = (state_q == S_RD_REQ);
  assign m_axi_araddr  = m_axi_arvalid ? (DMA_BASE + (ch_q ? 32'h34 : 32'h04)) : 32'd0;
  assign m_axi_rready  = (state_q == S_RD_RESP);

endmodule

// File: tb/tb_axi_dma_job_sequencer.sv
// Directed bench for axi_dma_job_sequencer with a negedge-driven AXI4-Lite DMA register model.
`timescale 1ns/1ps
module tb_axi_dma_job_sequencer;
  localparam logic [31:0] BASE = 32'h4040_0000;
`ifdef AXI_DMA_SEQ_TIMEOUT_EN
  localparam int TB_TMO = 50;
`else
  localparam int TB_TMO = 100000;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] tx_addr = 32'd0;
  logic [31:0] rx_addr = 32'd0;
  logic [23:0] len_words = 24'd0;
  logic        busy, done;
  logic [2:0]  status;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
  logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
  logic [31:0] m_axi_rdata = 32'd0;

  axi_dma_job_sequencer #(.DMA_BASE(BASE), .POLL_INTERVAL(5), .TIMEOUT_CYCLES(TB_TMO)) dut (
    .clk(clk), .rstn(rstn), .start(start), .tx_addr(tx_addr), .rx_addr(rx_addr),
    .len_words(len_words), .busy(busy), .done(done), .status(status),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  // slave configuration (written by the test sequence only)
  int          aw_dly, w_dly, ar_dly, berr_idx, sr0_busy_n, sr1_busy_n, job_id;
  logic [31:0] sr0_busy_val, sr0_final, sr1_busy_val, sr1_final;

  // slave state and logs (written by the slave model only)
  int          seen_job, cyc, n_aw, n_w, n_b, n_ar, n_r, n_gap, rd0_cnt, rd1_cnt;
  int          aw_age, w_age, ar_age, first_ar_cyc, last_r_cyc;
  int          gaps[0:63];
  logic [31:0] aw_log[0:15], w_log[0:15], ar_log[0:63];
  bit          have_r, any_aw, any_ar, saw_aw_only, saw_w_only;
  bit          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [31:0] aw_hs_addr, w_hs_data, ar_hs_addr;

  int          n_checks = 0;
  int          n_fail = 0;
  int          start_cyc;
  logic [31:0] exp_off[0:5];

  // Handshakes decided at one negedge happen at the following posedge and are committed at the next negedge.
  always @(negedge clk) begin
    cyc++;
    if (job_id != seen_job) begin
      seen_job = job_id;
      n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; n_gap = 0; rd0_cnt = 0; rd1_cnt = 0;
      first_ar_cyc = -1; have_r = 0; any_aw = 0; any_ar = 0; saw_aw_only = 0; saw_w_only = 0;
    end
    if (!rstn) begin
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
      aw_age = 0; w_age = 0; ar_age = 0;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0; m_axi_rvalid = 0;
    end else begin
      if (aw_hs) begin if (n_aw < 16) aw_log[n_aw] = aw_hs_addr; n_aw++; end
      if (w_hs)  begin if (n_w < 16) w_log[n_w] = w_hs_data; n_w++; end
      if (b_hs)  n_b++;
      if (r_hs)  begin n_r++; m_axi_rvalid = 0; have_r = 1; end
      if (ar_hs) begin
        if (n_ar < 64) ar_log[n_ar] = ar_hs_addr;
        n_ar++;
        if (ar_hs_addr == BASE + 32'h34) begin
          m_axi_rdata = (rd1_cnt < sr1_busy_n) ? sr1_busy_val : sr1_final; rd1_cnt++;
        end else begin
          m_axi_rdata = (rd0_cnt < sr0_busy_n) ? sr0_busy_val : sr0_final; rd0_cnt++;
        end
        m_axi_rresp = 2'b00;
        m_axi_rvalid = 1;
      end
      if (m_axi_awvalid) begin any_aw = 1; aw_age++; end else aw_age = 0;
      if (m_axi_wvalid) w_age++; else w_age = 0;
      if (m_axi_arvalid) begin any_ar = 1; ar_age++; end else ar_age = 0;
      if (m_axi_awvalid && !m_axi_wvalid) saw_aw_only = 1;
      if (m_axi_wvalid && !m_axi_awvalid) saw_w_only = 1;
      if (m_axi_arvalid && ar_age == 1) begin
        if (first_ar_cyc < 0) first_ar_cyc = cyc;
        if (have_r && n_gap < 64) begin gaps[n_gap] = cyc - last_r_cyc - 1; n_gap++; end
      end
      m_axi_awready = m_axi_awvalid && (aw_age > aw_dly);
      m_axi_wready  = m_axi_wvalid && (w_age > w_dly);
      m_axi_arready = m_axi_arvalid && (ar_age > ar_dly);
      m_axi_bvalid  = (n_aw > n_b) && (n_w > n_b);
      m_axi_bresp   = (n_b == berr_idx) ? 2'b10 : 2'b00;
      aw_hs = m_axi_awvalid && m_axi_awready; aw_hs_addr = m_axi_awaddr;
      w_hs  = m_axi_wvalid && m_axi_wready;   w_hs_data  = m_axi_wdata;
      b_hs  = m_axi_bvalid && m_axi_bready;
      ar_hs = m_axi_arvalid && m_axi_arready; ar_hs_addr = m_axi_araddr;
      r_hs  = m_axi_rvalid && m_axi_rready;
      if (r_hs) last_r_cyc = cyc;
    end
  end

  task automatic slave_defaults();
    aw_dly = 0; w_dly = 0; ar_dly = 0; berr_idx = -1;
    sr0_busy_n = 0; sr0_busy_val = 32'h0; sr0_final = 32'h2;
    sr1_busy_n = 0; sr1_busy_val = 32'h0; sr1_final = 32'h2;
  endtask

  task automatic do_reset();
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_job(input logic [31:0] tx, input logic [31:0] rx, input logic [23:0] len,
                         input int budget, input int poke_at,
                         output bit got_done, output logic [2:0] st,
                         output logic busy1, output logic aw1, output logic done1);
    job_id++;
    @(negedge clk);
    #1;
    start_cyc = cyc;
    tx_addr = tx; rx_addr = rx; len_words = len; start = 1'b1;
    @(posedge clk);
    #1;
    busy1 = busy; aw1 = m_axi_awvalid; done1 = done;
    @(negedge clk);
    start = 1'b0;
    got_done = 0; st = 3'd0;
    if (done) begin got_done = 1; st = status; end
    for (int i = 0; i < budget && !got_done; i++) begin
      @(negedge clk);
      start = (i == poke_at);
      if (start) begin tx_addr = 32'hDEAD_0000; rx_addr = 32'hBEEF_0000; end
      if (done) begin got_done = 1; st = status; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000000", {busy, done, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready});
    end
    n_checks++;
    if (status !== 3'd0) begin n_fail++; $display("FAIL reset_status: got %0d want 0", status); end
    n_checks++;
    if ({m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_wstrb} !== 100'd0) begin
      n_fail++; $display("FAIL reset_bus: aw=%h w=%h ar=%h want 0", m_axi_awaddr, m_axi_wdata, m_axi_araddr);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, m_axi_awvalid} !== 3'b0) begin n_fail++; $display("FAIL reset_release: busy/done/awvalid=%b want 000", {busy, done, m_axi_awvalid}); end
  endtask

  task automatic test_basic();
    bit got; logic [2:0] st; logic b1, a1, d1;
    logic [31:0] exp_data[0:5];
    slave_defaults();
    exp_data = '{32'h0010_4000, 32'h0010_0000, 32'h1, 32'h1, 32'd32, 32'd32};
    run_job(32'h0010_0000, 32'h0010_4000, 24'd8, 3000, -1, got, st, b1, a1, d1);
    n_checks++;
    if ({b1, a1} !== 2'b11) begin n_fail++; $display("FAIL basic_start_edge: busy,awvalid=%b want 11", {b1, a1}); end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL basic_done: no done within budget"); end
    n_checks++;
    if (st !== 3'd0) begin n_fail++; $display("FAIL basic_status: got %0d want 0", st); end
    n_checks++;
    if (n_aw !== 6 || n_w !== 6) begin n_fail++; $display("FAIL basic_wcount: aw=%0d w=%0d want 6/6", n_aw, n_w); end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (aw_log[i] !== BASE + exp_off[i] || w_log[i] !== exp_data[i]) begin
        n_fail++; $display("FAIL basic_write%0d: got %h=%h want %h=%h", i, aw_log[i], w_log[i], BASE + exp_off[i], exp_data[i]);
      end
    end
    n_checks++;
    if (first_ar_cyc - start_cyc !== 13) begin n_fail++; $display("FAIL basic_write_phase: first AR %0d cycles after start want 13", first_ar_cyc - start_cyc); end
    n_checks++;
    if (n_ar !== 2 || ar_log[0] !== BASE + 32'h4 || ar_log[1] !== BASE + 32'h34) begin
      n_fail++; $display("FAIL basic_reads: n=%0d a0=%h a1=%h want 2 40400004 40400034", n_ar, ar_log[0], ar_log[1]);
    end
    @(negedge clk);
    n_checks++;
    if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL basic_after_done: done,busy=%b want 00", {done, busy}); end
  endtask

  task automatic test_badlen();
    bit got; logic [2:0] st; logic b1, a1, d1;
    slave_defaults();
    run_job(32'h0010_0000, 32'h0010_4000, 24'd0, 50, -1, got, st, b1, a1, d1);
    n_checks++;
    if ({d1, b1, a1} !== 3'b100) begin n_fail++; $display("FAIL badlen_edge: done,busy,awvalid=%b want 100", {d1, b1, a1}); end
    n_checks++;
    if (st !== 3'd4) begin n_fail++; $display("FAIL badlen_status: got %0d want 4", st); end
    repeat (5) @(negedge clk);
    n_checks++;
    if ({any_aw, any_ar, done, busy} !== 4'b0) begin n_fail++; $display("FAIL badlen_traffic: aw,ar,done,busy=%b want 0000", {any_aw, any_ar, done, busy}); end
  endtask

  task automatic test_bus_error();
    bit got; logic [2:0] st; logic b1, a1, d1;
    slave_defaults();
    berr_idx = 2;
    run_job(32'h0020_0000, 32'h0030_0000, 24'd4, 3000, -1, got, st, b1, a1, d1);
    n_checks++;
    if (!got || st !== 3'd1) begin n_fail++; $display("FAIL buserr_status: done=%0d status=%0d want 1/1", got, st); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_aw !== 3 || any_ar || busy) begin n_fail++; $display("FAIL buserr_stop: aw=%0d ar=%0d busy=%0d want 3/0/0", n_aw, any_ar, busy); end
  endtask

  task automatic test_poll_wait();
    bit got; logic [2:0] st; logic b1, a1, d1;
    slave_defaults();
    sr0_busy_n = 3;
    run_job(32'h0010_0000, 32'h0010_4000, 24'd16, 3000, -1, got, st, b1, a1, d1);
    n_checks++;
    if (!got || st !== 3'd0) begin n_fail++; $display("FAIL poll_status: done=%0d status=%0d want 1/0", got, st); end
    n_checks++;
    if (n_ar !== 5 || ar_log[3] !== BASE + 32'h4 || ar_log[4] !== BASE + 32'h34) begin
      n_fail++; $display("FAIL poll_reads: n=%0d a3=%h a4=%h want 5 40400004 40400034", n_ar, ar_log[3], ar_log[4]);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (gaps[i] !== 5) begin n_fail++; $display("FAIL poll_gap%0d: got %0d cycles want 5", i, gaps[i]); end
    end
    n_checks++;
    if (gaps[3] !== 0) begin n_fail++; $display("FAIL poll_ch_advance: got %0d cycles want 0", gaps[3]); end
  endtask

  task automatic test_dmaerr();
    bit got; logic [2:0] st; logic b1, a1, d1;
    slave_defaults();
    sr1_final = 32'h12;
    run_job(32'h0010_0000, 32'h0010_4000, 24'd8, 3000, -1, got, st, b1, a1, d1);
    n_checks++;
    if (!got || st !== 3'd2) begin n_fail++; $display("FAIL dmaerr_status: done=%0d status=%0d want 1/2", got, st); end
  endtask

  task automatic test_write_stall();
    bit got; logic [2:0] st; logic b1, a1, d1;
    for (int k = 0; k < 2; k++) begin
      slave_defaults();
      aw_dly = (k == 0) ? 2 : 0;
      w_dly  = (k == 0) ? 0 : 3;
      run_job(32'h0A00_0000, 32'h0B00_0000, 24'd3, 3000, -1, got, st, b1, a1, d1);
      n_checks++;
      if (!got || st !== 3'd0 || n_aw !== 6 || n_w !== 6) begin
        n_fail++; $display("FAIL stall%0d_count: done=%0d status=%0d aw=%0d w=%0d want 1/0/6/6", k, got, st, n_aw, n_w);
      end
      n_checks++;
      if (aw_log[0] !== BASE + 32'h48 || w_log[0] !== 32'h0B00_0000 || aw_log[5] !== BASE + 32'h28 || w_log[5] !== 32'd12) begin
        n_fail++; $display("FAIL stall%0d_data: %h=%h %h=%h", k, aw_log[0], w_log[0], aw_log[5], w_log[5]);
      end
      n_checks++;
      if ((k == 0 && !saw_aw_only) || (k == 1 && !saw_w_only)) begin
        n_fail++; $display("FAIL stall%0d_indep: aw_only=%0d w_only=%0d", k, saw_aw_only, saw_w_only);
      end
    end
  endtask

  task automatic test_busy_ignore();
    bit got; logic [2:0] st; logic b1, a1, d1;
    slave_defaults();
    run_job(32'h0010_0000, 32'h0010_4000, 24'd8, 3000, 3, got, st, b1, a1, d1);
    n_checks++;
    if (!got || n_aw !== 6 || w_log[0] !== 32'h0010_4000) begin
      n_fail++; $display("FAIL busy_ignore_job: done=%0d aw=%0d w0=%h want 1/6/00104000", got, n_aw, w_log[0]);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || n_aw !== 6) begin n_fail++; $display("FAIL busy_ignore_queue: busy=%0d aw=%0d want 0/6", busy, n_aw); end
  endtask

  task automatic test_back_to_back();
    bit got; logic [2:0] st; logic b1, a1, d1;
    slave_defaults();
    run_job(32'h1000_0000, 32'h2000_0000, 24'hFF_FFFF, 3000, -1, got, st, b1, a1, d1);
    n_checks++;
    if (!got || st !== 3'd0 || w_log[4] !== 32'h03FF_FFFC || w_log[5] !== 32'h03FF_FFFC) begin
      n_fail++; $display("FAIL b2b_maxlen: done=%0d status=%0d len=%h/%h want 03fffffc", got, st, w_log[4], w_log[5]);
    end
    run_job(32'h1100_0000, 32'h2200_0000, 24'd1, 3000, -1, got, st, b1, a1, d1);
    n_checks++;
    if (!got || st !== 3'd0 || b1 !== 1'b1 || w_log[1] !== 32'h1100_0000 || w_log[4] !== 32'd4) begin
      n_fail++; $display("FAIL b2b_second: done=%0d status=%0d busy1=%0d tx=%h len=%h", got, st, b1, w_log[1], w_log[4]);
    end
  endtask

  task automatic test_reset_mid_job();
    slave_defaults();
    job_id++;
    @(negedge clk);
    #1;
    tx_addr = 32'h0010_0000; rx_addr = 32'h0010_4000; len_words = 24'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({busy, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid} !== 5'b0 || m_axi_awaddr !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid_job: busy,aw,w,b,ar=%b awaddr=%h want 0", {busy, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid}, m_axi_awaddr);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

`ifdef AXI_DMA_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    bit got; logic [2:0] st; logic b1, a1, d1;
    slave_defaults();
    sr0_busy_n = 100000;
    run_job(32'h0010_0000, 32'h0010_4000, 24'd8, 3000, -1, got, st, b1, a1, d1);
    n_checks++;
    if (!got || st !== 3'd3) begin n_fail++; $display("FAIL timeout_status: done=%0d status=%0d want 1/3", got, st); end
  endtask
`else
  task automatic test_no_timeout();
    bit got; logic [2:0] st; logic b1, a1, d1;
    slave_defaults();
    sr0_busy_n = 100000;
    run_job(32'h0010_0000, 32'h0010_4000, 24'd8, 300, -1, got, st, b1, a1, d1);
    n_checks++;
    if (got || busy !== 1'b1 || n_ar < 20) begin
      n_fail++; $display("FAIL no_timeout_polls: done=%0d busy=%0d reads=%0d want 0/1/>=20", got, busy, n_ar);
    end
    do_reset();
  endtask
`endif

  initial begin
    exp_off = '{32'h48, 32'h18, 32'h00, 32'h30, 32'h58, 32'h28};
    job_id = 0; seen_job = 0; cyc = 0;
    slave_defaults();
    test_reset();
    test_basic();
    test_badlen();
    test_bus_error();
    test_poll_wait();
    test_dmaerr();
    test_write_stall();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_job();
`ifdef AXI_DMA_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
